// File: rtl/intadd_pkg.sv
// Shared constants, lane-width helper and stage payload type for the pipelined SIMD integer adder.
package intadd_pkg;

    localparam logic [1:0] PREC_8  = 2'b00;
    localparam logic [1:0] PREC_16 = 2'b01;
    localparam logic [1:0] PREC_32 = 2'b11;

    // Widest supported DATA_W; narrower instances leave the upper payload bits at zero.
    localparam int unsigned MAX_DATA_W = 256;

    function automatic int unsigned lane_w(input logic [1:0] prec);
        case (prec)
            PREC_8:  return 8;
            PREC_16: return 16;
            PREC_32: return 32;
            default: return 0;
        endcase
    endfunction

    typedef struct packed {
        logic [MAX_DATA_W-1:0]   dst;
        logic [MAX_DATA_W/8-1:0] ovf;
        logic                    illegal;
    } payload_t;

    typedef struct packed {
        logic        ovf;
        logic [31:0] res;
    } lane_res_t;

endpackage

// File: rtl/intadd_simd_core.sv
// Combinational lane-segmented adder: 8/16/32-bit lanes, per-source signedness, wrap or saturate.
module intadd_simd_core
    import intadd_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [1:0]          prec_i,
    input  logic                sign0_i,
    input  logic                sign1_i,
    input  logic                sat_i,
    output logic [DATA_W-1:0]   dst_o,
    output logic [DATA_W/8-1:0] ovf_o,
    output logic                illegal_o
);

    // Operands arrive right-aligned in 32 bits; 34-bit signed arithmetic holds any exact lane sum.
    function automatic lane_res_t lane_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] prec, input logic s0,
                                           input logic s1, input logic sat);
        int                 w;
        logic [33:0]        ax, bx;
        logic signed [33:0] ae, be, sum, hi, lo, clamp;
        logic [31:0]        mask;
        lane_res_t          r;
        w  = int'(lane_w(prec));
        ax = {2'b00, a};
        bx = {2'b00, b};
        for (int i = 0; i < 34; i++) begin
            ae[i] = (i < w) ? ax[i] : (s0 & a[w-1]);
            be[i] = (i < w) ? bx[i] : (s1 & b[w-1]);
        end
        sum = ae + be;
        if (s0 | s1) begin
            hi = (34'sd1 <<< (w - 1)) - 34'sd1;
            lo = -(34'sd1 <<< (w - 1));
        end else begin
            hi = (34'sd1 <<< w) - 34'sd1;
            lo = '0;
        end
        r.ovf = (sum > hi) || (sum < lo);
        clamp = (sum > hi) ? hi : lo;
        mask  = ~(32'hFFFF_FFFF << w);
        r.res = ((sat && r.ovf) ? clamp[31:0] : sum[31:0]) & mask;
        return r;
    endfunction

    always_comb begin
        lane_res_t r;
        r         = '0;
        dst_o     = '0;
        ovf_o     = '0;
        illegal_o = 1'b0;
        unique case (prec_i)
            PREC_8: begin
                for (int i = 0; i < int'(DATA_W / 8); i++) begin
                    r = lane_add({24'b0, a_i[8*i+:8]}, {24'b0, b_i[8*i+:8]}, prec_i,
                                 sign0_i, sign1_i, sat_i);
                    dst_o[8*i+:8] = r.res[7:0];
                    ovf_o[i]      = r.ovf;
                end
            end
            PREC_16: begin
                for (int i = 0; i < int'(DATA_W / 16); i++) begin
                    r = lane_add({16'b0, a_i[16*i+:16]}, {16'b0, b_i[16*i+:16]}, prec_i,
                                 sign0_i, sign1_i, sat_i);
                    dst_o[16*i+:16] = r.res[15:0];
                    ovf_o[2*i+:2]   = {2{r.ovf}};
                end
            end
            PREC_32: begin
                for (int i = 0; i < int'(DATA_W / 32); i++) begin
                    r = lane_add(a_i[32*i+:32], b_i[32*i+:32], prec_i,
                                 sign0_i, sign1_i, sat_i);
                    dst_o[32*i+:32] = r.res;
                    ovf_o[4*i+:4]   = {4{r.ovf}};
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/intadd_simd_pipe.sv
// Pipelined SIMD integer adder: arithmetic in stage 0, then delay stages, valid/ready on both sides.
module intadd_simd_pipe
    import intadd_pkg::*;
#(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   src_reg0,
    input  logic [DATA_W-1:0]   src_reg1,
    input  logic [1:0]          precision,
    input  logic                sign_s0,
    input  logic                sign_s1,
    input  logic                sat_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   dst_reg0,
    output logic [DATA_W/8-1:0] ovf_flags,
    output logic                illegal_prec
);

    logic [DATA_W-1:0]   core_dst;
    logic [DATA_W/8-1:0] core_ovf;
    logic                core_ill;
    payload_t            core_pl;

    logic [PIPE_STAGES-1:0] valid_q, valid_d, adv;
    payload_t               stage_q [PIPE_STAGES];
    payload_t               stage_d [PIPE_STAGES];

    intadd_simd_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a_i       (src_reg0),
        .b_i       (src_reg1),
        .prec_i    (precision),
        .sign0_i   (sign_s0),
        .sign1_i   (sign_s1),
        .sat_i     (sat_en),
        .dst_o     (core_dst),
        .ovf_o     (core_ovf),
        .illegal_o (core_ill)
    );

    always_comb begin
        core_pl                     = '0;
        core_pl.dst[DATA_W-1:0]     = core_dst;
        core_pl.ovf[DATA_W/8-1:0]   = core_ovf;
        core_pl.illegal             = core_ill;
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv[PIPE_STAGES-1] = !valid_q[PIPE_STAGES-1] || out_ready;
        for (int k = int'(PIPE_STAGES) - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) stage_d[0] = core_pl;
        end
        for (int k = 1; k < int'(PIPE_STAGES); k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < int'(PIPE_STAGES); k++) stage_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    assign in_ready     = adv[0];
    assign out_valid    = valid_q[PIPE_STAGES-1];
    assign dst_reg0     = stage_q[PIPE_STAGES-1].dst[DATA_W-1:0];
    assign ovf_flags    = stage_q[PIPE_STAGES-1].ovf[DATA_W/8-1:0];
    assign illegal_prec = stage_q[PIPE_STAGES-1].illegal;

    if (DATA_W < MAX_DATA_W) begin : g_narrow
        logic unused_pl;
        assign unused_pl = ^{stage_q[PIPE_STAGES-1].dst[MAX_DATA_W-1:DATA_W],
                             stage_q[PIPE_STAGES-1].ovf[MAX_DATA_W/8-1:DATA_W/8]};
    end

endmodule
